// File: rtl/mul_rs.sv
// Reservation station and oldest-ready issue scheduler for the iterative multiplier.
// Optional MUL_RS_WAKEUP_BYPASS_EN: a same-cycle CDB hit counts toward eligibility.
module mul_rs #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        disp_valid,
  output logic        disp_ready,
  input  logic [2:0]  disp_funct3,
  input  logic [2:0]  disp_rob_idx,
  input  logic [6:0]  disp_rd,
  input  logic        disp_rs1_rdy,
  input  logic        disp_rs2_rdy,
  input  logic [2:0]  disp_rs1_tag,
  input  logic [2:0]  disp_rs2_tag,
  input  logic [31:0] disp_rs1_data,
  input  logic [31:0] disp_rs2_data,
  input  logic        cdb_valid,
  input  logic [2:0]  cdb_rob_idx,
  input  logic [31:0] cdb_data,
  input  logic        mul_idle,
  output logic        mul_i_valid,
  output logic [2:0]  mul_funct3,
  output logic [31:0] mul_rs1_data,
  output logic [31:0] mul_rs2_data,
  output logic [2:0]  mul_i_rob_idx,
  output logic [6:0]  mul_i_rd,
  output logic [3:0]  rs_count
);
  localparam int unsigned CNT_W = 4;

  typedef struct packed {
    logic        valid;
    logic [2:0]  f3;
    logic [2:0]  rob;
    logic [6:0]  rd;
    logic        r1;
    logic [2:0]  t1;
    logic [31:0] d1;
    logic        r2;
    logic [2:0]  t2;
    logic [31:0] d2;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  entry_t           wk    [DEPTH+1];
  entry_t           new_e;
  entry_t           cand;
  entry_t           iss_e;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] sel;
  logic [CNT_W-1:0] wr_idx;
  logic             any_elig;
  logic             issue;
  logic             accept;

  // Capture a broadcast into any waiting operand of a valid entry.
  function automatic entry_t wake(input entry_t e, input logic v,
                                  input logic [2:0] tag, input logic [31:0] d);
    entry_t w;
    w = e;
    if (v && e.valid) begin
      if (!e.r1 && e.t1 == tag) begin
        w.r1 = 1'b1;
        w.d1 = d;
      end
      if (!e.r2 && e.t2 == tag) begin
        w.r2 = 1'b1;
        w.d2 = d;
      end
    end
    return w;
  endfunction

  always_comb begin
    new_e       = '0;
    new_e.valid = 1'b1;
    new_e.f3    = disp_funct3;
    new_e.rob   = disp_rob_idx;
    new_e.rd    = disp_rd;
    new_e.r1    = disp_rs1_rdy;
    new_e.t1    = disp_rs1_tag;
    new_e.d1    = disp_rs1_data;
    new_e.r2    = disp_rs2_rdy;
    new_e.t2    = disp_rs2_tag;
    new_e.d2    = disp_rs2_data;
    new_e       = wake(new_e, cdb_valid, cdb_rob_idx, cdb_data);
    for (int i = 0; i < DEPTH; i++) begin
      wk[i] = wake(ent_q[i], cdb_valid, cdb_rob_idx, cdb_data);
    end
    wk[DEPTH] = '0;
  end

  // Oldest-first select; the first eligible slot wins.
  always_comb begin
    any_elig = 1'b0;
    sel      = '0;
    iss_e    = '0;
    cand     = '0;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef MUL_RS_WAKEUP_BYPASS_EN
      cand = wk[i];
`else
      cand = ent_q[i];
`endif
      if (!any_elig && cand.valid && cand.r1 && cand.r2) begin
        any_elig = 1'b1;
        sel      = CNT_W'(i);
        iss_e    = cand;
      end
    end
  end

  assign disp_ready    = cnt_q < CNT_W'(DEPTH);
  assign issue         = mul_idle && any_elig && !flush;
  assign accept        = disp_valid && disp_ready && !flush;
  assign mul_i_valid   = issue;
  assign mul_funct3    = issue ? iss_e.f3  : '0;
  assign mul_rs1_data  = issue ? iss_e.d1  : '0;
  assign mul_rs2_data  = issue ? iss_e.d2  : '0;
  assign mul_i_rob_idx = issue ? iss_e.rob : '0;
  assign mul_i_rd      = issue ? iss_e.rd  : '0;
  assign rs_count      = cnt_q;

  // Compact over the issued slot, then append the dispatch at the new tail.
  always_comb begin
    wr_idx = cnt_q - CNT_W'(issue);
    cnt_d  = cnt_q + CNT_W'(accept) - CNT_W'(issue);
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = (issue && CNT_W'(i) >= sel) ? wk[i+1] : wk[i];
      if (accept && CNT_W'(i) == wr_idx) ent_d[i] = new_e;
      if (flush) ent_d[i] = '0;
    end
    if (flush) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end
endmodule

// File: tb/tb_mul_rs.sv
// Scoreboard bench for mul_rs: expected issues queued at dispatch, checked on issue.
module tb_mul_rs;
  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        disp_valid;
  logic        disp_ready;
  logic [2:0]  disp_funct3;
  logic [2:0]  disp_rob_idx;
  logic [6:0]  disp_rd;
  logic        disp_rs1_rdy, disp_rs2_rdy;
  logic [2:0]  disp_rs1_tag, disp_rs2_tag;
  logic [31:0] disp_rs1_data, disp_rs2_data;
  logic        cdb_valid;
  logic [2:0]  cdb_rob_idx;
  logic [31:0] cdb_data;
  logic        mul_idle;
  logic        mul_i_valid;
  logic [2:0]  mul_funct3;
  logic [31:0] mul_rs1_data, mul_rs2_data;
  logic [2:0]  mul_i_rob_idx;
  logic [6:0]  mul_i_rd;
  logic [3:0]  rs_count;

  typedef struct packed {
    logic [2:0]  f3;
    logic [2:0]  rob;
    logic [6:0]  rd;
    logic [31:0] d1;
    logic [31:0] d2;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

`ifdef MUL_RS_WAKEUP_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  mul_rs #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_funct3(disp_funct3), .disp_rob_idx(disp_rob_idx), .disp_rd(disp_rd),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
    .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag),
    .disp_rs1_data(disp_rs1_data), .disp_rs2_data(disp_rs2_data),
    .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx), .cdb_data(cdb_data),
    .mul_idle(mul_idle), .mul_i_valid(mul_i_valid), .mul_funct3(mul_funct3),
    .mul_rs1_data(mul_rs1_data), .mul_rs2_data(mul_rs2_data),
    .mul_i_rob_idx(mul_i_rob_idx), .mul_i_rd(mul_i_rd), .rs_count(rs_count)
  );

  always #5 clk = ~clk;

  // Scoreboard: every issue must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst) begin
      if (mul_i_valid) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_issue rob=%0d rd=%0d", mul_i_rob_idx, mul_i_rd);
        end else begin
          exp_t e;
          exp_t got;
          e   = exp_q.pop_front();
          got = {mul_funct3, mul_i_rob_idx, mul_i_rd, mul_rs1_data, mul_rs2_data};
          if (got !== e) begin
            n_fail++;
            $display("FAIL issue_payload got f3=%0d rob=%0d rd=%0d rs1=%h rs2=%h exp f3=%0d rob=%0d rd=%0d rs1=%h rs2=%h",
                     got.f3, got.rob, got.rd, got.d1, got.d2, e.f3, e.rob, e.rd, e.d1, e.d2);
          end
        end
      end else begin
        n_tests++;
        if ({mul_funct3, mul_i_rob_idx, mul_i_rd, mul_rs1_data, mul_rs2_data} !== '0) begin
          n_fail++;
          $display("FAIL idle_outputs_zero got rs1=%h rs2=%h rob=%0d exp 0", mul_rs1_data, mul_rs2_data, mul_i_rob_idx);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    disp_valid = 1'b0;
    cdb_valid  = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic disp(input logic [2:0] f3, input logic [2:0] rob, input logic [6:0] rd,
                      input logic r1, input logic [2:0] t1, input logic [31:0] d1,
                      input logic r2, input logic [2:0] t2, input logic [31:0] d2);
    disp_valid    = 1'b1;
    disp_funct3   = f3;
    disp_rob_idx  = rob;
    disp_rd       = rd;
    disp_rs1_rdy  = r1;
    disp_rs1_tag  = t1;
    disp_rs1_data = d1;
    disp_rs2_rdy  = r2;
    disp_rs2_tag  = t2;
    disp_rs2_data = d2;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    quiet();
    mul_idle = 1'b1;
    disp_funct3 = '0; disp_rob_idx = '0; disp_rd = '0;
    disp_rs1_rdy = 1'b0; disp_rs2_rdy = 1'b0; disp_rs1_tag = '0; disp_rs2_tag = '0;
    disp_rs1_data = '0; disp_rs2_data = '0; cdb_rob_idx = '0; cdb_data = '0;
    #12;
    n_tests++;
    if ({disp_ready, mul_i_valid, rs_count} !== {1'b1, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_state got rdy=%b iv=%b cnt=%0d exp rdy=1 iv=0 cnt=0", disp_ready, mul_i_valid, rs_count);
    end
    n_tests++;
    if ({mul_rs1_data, mul_rs2_data, mul_i_rob_idx, mul_i_rd, mul_funct3} !== '0) begin
      n_fail++;
      $display("FAIL reset_data got rs1=%h rs2=%h exp 0", mul_rs1_data, mul_rs2_data);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    tick();
    mul_idle = 1'b1;
    disp(3'd0, 3'd2, 7'd5, 1'b1, 3'd0, 32'd7, 1'b1, 3'd0, 32'd6);
    exp_q.push_back({3'd0, 3'd2, 7'd5, 32'd7, 32'd6});
    @(negedge clk);
    n_tests++;
    if (mul_i_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_no_issue_c0 got %b exp 0", mul_i_valid);
    end
    tick();
    quiet();
    @(negedge clk);
    n_tests++;
    if ({mul_i_valid, rs_count} !== {1'b1, 4'd1}) begin
      n_fail++;
      $display("FAIL basic_issue_c1 got iv=%b cnt=%0d exp iv=1 cnt=1", mul_i_valid, rs_count);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if ({mul_i_valid, rs_count} !== {1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL basic_drain got iv=%b cnt=%0d exp iv=0 cnt=0", mul_i_valid, rs_count);
    end
  endtask

  task automatic test_wakeup();
    tick();
    mul_idle = 1'b1;
    disp(3'd1, 3'd4, 7'd9, 1'b1, 3'd0, 32'h1234, 1'b0, 3'd3, 32'd0);
    tick();
    quiet();
    cdb_valid = 1'b1; cdb_rob_idx = 3'd5; cdb_data = 32'h5555_5555;
    @(negedge clk);
    n_tests++;
    if ({mul_i_valid, rs_count} !== {1'b0, 4'd1}) begin
      n_fail++;
      $display("FAIL wakeup_nomatch got iv=%b cnt=%0d exp iv=0 cnt=1", mul_i_valid, rs_count);
    end
    tick();
    quiet();
    @(negedge clk);
    n_tests++;
    if (mul_i_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wakeup_waiting got %b exp 0", mul_i_valid);
    end
    tick();
    cdb_valid = 1'b1; cdb_rob_idx = 3'd3; cdb_data = 32'hFFFF_FFFF;
    exp_q.push_back({3'd1, 3'd4, 7'd9, 32'h1234, 32'hFFFF_FFFF});
    @(negedge clk);
    n_tests++;
    if (mul_i_valid !== BYP) begin
      n_fail++;
      $display("FAIL wakeup_cdb_cycle got %b exp %b", mul_i_valid, BYP);
    end
    tick();
    quiet();
    @(negedge clk);
    n_tests++;
    if (mul_i_valid !== !BYP) begin
      n_fail++;
      $display("FAIL wakeup_next_cycle got %b exp %b", mul_i_valid, !BYP);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (rs_count !== 4'd0) begin
      n_fail++;
      $display("FAIL wakeup_drain got %0d exp 0", rs_count);
    end
  endtask

  task automatic test_age_order();
    tick();
    mul_idle = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(3'(i), 3'(i), 7'(10 + i), 1'b1, 3'd0, 32'(100 + i), 1'b1, 3'd0, 32'(200 + i));
      exp_q.push_back({3'(i), 3'(i), 7'(10 + i), 32'(100 + i), 32'(200 + i)});
      tick();
    end
    quiet();
    @(negedge clk);
    n_tests++;
    if ({rs_count, disp_ready, mul_i_valid} !== {4'd4, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL age_full got cnt=%0d rdy=%b iv=%b exp cnt=4 rdy=0 iv=0", rs_count, disp_ready, mul_i_valid);
    end
    tick();
    disp(3'd7, 3'd7, 7'd99, 1'b1, 3'd0, 32'd1, 1'b1, 3'd0, 32'd2);
    mul_idle = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({disp_ready, mul_i_valid} !== {1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL age_full_disp_issue got rdy=%b iv=%b exp rdy=0 iv=1", disp_ready, mul_i_valid);
    end
    tick();
    quiet();
    mul_idle = 1'b0;
    @(negedge clk);
    n_tests++;
    if (rs_count !== 4'd3) begin
      n_fail++;
      $display("FAIL age_refused_disp got cnt=%0d exp 3", rs_count);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      mul_idle = 1'b1;
      @(negedge clk);
      n_tests++;
      if (mul_i_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL age_pulse%0d got %b exp 1", i, mul_i_valid);
      end
      tick();
      mul_idle = 1'b0;
    end
    @(negedge clk);
    n_tests++;
    if ({rs_count, 32'(exp_q.size())} !== {4'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL age_drain got cnt=%0d pending=%0d exp 0 0", rs_count, exp_q.size());
    end
  endtask

  task automatic test_ooo();
    int waited;
    tick();
    mul_idle = 1'b0;
    disp(3'd2, 3'd1, 7'd20, 1'b0, 3'd6, 32'd0, 1'b1, 3'd0, 32'h0000_0003);
    tick();
    disp(3'd3, 3'd2, 7'd21, 1'b1, 3'd0, 32'h0000_0011, 1'b1, 3'd0, 32'h0000_0022);
    exp_q.push_back({3'd3, 3'd2, 7'd21, 32'h11, 32'h22});
    tick();
    quiet();
    mul_idle = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({mul_i_valid, mul_i_rob_idx} !== {1'b1, 3'd2}) begin
      n_fail++;
      $display("FAIL ooo_younger_first got iv=%b rob=%0d exp iv=1 rob=2", mul_i_valid, mul_i_rob_idx);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (mul_i_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ooo_blocked got %b exp 0", mul_i_valid);
    end
    tick();
    cdb_valid = 1'b1; cdb_rob_idx = 3'd6; cdb_data = 32'hDEAD_BEEF;
    disp(3'd0, 3'd5, 7'd22, 1'b1, 3'd0, 32'h0000_0077, 1'b0, 3'd6, 32'd0);
    exp_q.push_back({3'd2, 3'd1, 7'd20, 32'hDEAD_BEEF, 32'h3});
    exp_q.push_back({3'd0, 3'd5, 7'd22, 32'h77, 32'hDEAD_BEEF});
    @(negedge clk);
    n_tests++;
    if (mul_i_valid !== BYP) begin
      n_fail++;
      $display("FAIL ooo_cdb_cycle got %b exp %b", mul_i_valid, BYP);
    end
    waited = 0;
    tick();
    quiet();
    while (exp_q.size() != 0 && waited < 10) begin
      tick();
      waited++;
    end
    n_tests++;
    if ({32'(exp_q.size()), rs_count} !== {32'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL ooo_drain got pending=%0d cnt=%0d exp 0 0", exp_q.size(), rs_count);
    end
  endtask

  task automatic test_flush();
    tick();
    mul_idle = 1'b0;
    for (int i = 0; i < 3; i++) begin
      disp(3'd0, 3'(i), 7'(40 + i), 1'b1, 3'd0, 32'(i), 1'b1, 3'd0, 32'(i));
      tick();
    end
    disp(3'd0, 3'd3, 7'd43, 1'b1, 3'd0, 32'd3, 1'b1, 3'd0, 32'd3);
    flush = 1'b1;
    mul_idle = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({mul_i_valid, rs_count} !== {1'b0, 4'd3}) begin
      n_fail++;
      $display("FAIL flush_cycle got iv=%b cnt=%0d exp iv=0 cnt=3", mul_i_valid, rs_count);
    end
    tick();
    quiet();
    @(negedge clk);
    n_tests++;
    if ({mul_i_valid, rs_count} !== {1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL flush_after got iv=%b cnt=%0d exp iv=0 cnt=0", mul_i_valid, rs_count);
    end
    repeat (4) tick();
  endtask

  task automatic test_async_reset();
    tick();
    mul_idle = 1'b0;
    disp(3'd1, 3'd1, 7'd50, 1'b1, 3'd0, 32'd5, 1'b1, 3'd0, 32'd6);
    tick();
    disp(3'd1, 3'd2, 7'd51, 1'b1, 3'd0, 32'd7, 1'b1, 3'd0, 32'd8);
    tick();
    quiet();
    #2;
    n_tests++;
    if (rs_count !== 4'd2) begin
      n_fail++;
      $display("FAIL areset_pre got %0d exp 2", rs_count);
    end
    rst = 1'b0;
    mul_idle = 1'b1;
    #1;
    n_tests++;
    if ({rs_count, mul_i_valid} !== {4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL areset_immediate got cnt=%0d iv=%b exp cnt=0 iv=0", rs_count, mul_i_valid);
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    n_tests++;
    if ({rs_count, mul_i_valid} !== {4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL areset_after got cnt=%0d iv=%b exp cnt=0 iv=0", rs_count, mul_i_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_age_order();
    test_ooo();
    test_flush();
    test_async_reset();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mul_rs.md
# mul_rs

Reservation station and issue scheduler for the iterative multiply unit in the out-of-order core. It buffers up to `DEPTH` dispatched M-extension multiply ops (MUL/MULH/MULHSU/MULHU) and captures missing operands from the common data bus (CDB). It issues the oldest ready op to the multiplier whenever the multiplier reports idle. It sits between dispatch/rename and the multiplier; the multiplier's result path goes straight to the CDB and is not touched here.

## Interface
- `DEPTH`, 4, number of entries (2..8).
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous active-low reset (0 = reset).
- `flush`  input  1  pipeline flush; clears all entries.
- `disp_valid`  input  1  dispatch request.
- `disp_ready`  output  1  entry available.
- `disp_funct3`  input  3  multiply funct3.
- `disp_rob_idx`  input  3  ROB index of the op; also its result tag.
- `disp_rd`  input  7  physical destination.
- `disp_rs1_rdy`, `disp_rs2_rdy`  input  1 each  operand already valid.
- `disp_rs1_tag`, `disp_rs2_tag`  input  3 each  producer ROB index when not ready.
- `disp_rs1_data`, `disp_rs2_data`  input  32 each  operand value when ready.
- `cdb_valid`  input  1  result broadcast.
- `cdb_rob_idx`  input  3  tag of the broadcast.
- `cdb_data`  input  32  broadcast value.
- `mul_idle`  input  1  multiplier can accept an op this cycle.
- `mul_i_valid`  output  1  issue strobe to the multiplier.
- `mul_funct3`  output  3  funct3 of the issued op.
- `mul_rs1_data`, `mul_rs2_data`  output  32 each  operands of the issued op.
- `mul_i_rob_idx`  output  3  ROB index of the issued op.
- `mul_i_rd`  output  7  destination of the issued op.
- `rs_count`  output  4  number of occupied entries.

## Operation
- **Storage.** Compacting age queue with slot 0 the oldest. Each entry holds:
  - valid bit
  - funct3, rob_idx, rd
  - per operand: ready bit, tag, 32-bit data
- **Dispatch.**
  - `disp_ready` = `rs_count < DEPTH`. It does not depend on a same-cycle issue.
  - A dispatch is accepted when `disp_valid && disp_ready && !flush`.
  - The new entry is written at slot `rs_count`, or at `rs_count-1` when an issue happens in the same cycle.
- **Wakeup.** When `cdb_valid` is high, every valid entry whose non-ready operand tag equals `cdb_rob_idx` sets that ready bit and captures `cdb_data`.
  - Wakeup also applies to the op being dispatched in the same cycle.
  - Both operands of one entry may wake on the same broadcast.
  - A broadcast that matches no entry has no effect.
- **Select.**
  - An entry is eligible when it is valid and both operands are ready, using registered ready bits.
  - `mul_i_valid` = `mul_idle && any eligible && !flush`.
  - The issued entry is the lowest eligible slot. All issue outputs are driven combinationally from that entry in the same cycle.
  - When `mul_i_valid` = 0, all issue data outputs are driven to 0.
- **Issue removal.** The issued entry is removed at the clock edge. Entries above it shift down one slot, which preserves age order. At most one issue per cycle.
- **Flush.**
  - Clears every valid bit at the next edge and `rs_count` becomes 0.
  - Flush overrides dispatch and issue in the same cycle.
  - An op already inside the multiplier is not cancelled.
- **funct3.** Passed through unchanged. Values outside the multiply set are stored and issued as given.

## Timing
- Reset (`rst` = 0), asynchronous: all valid bits clear and `rs_count` = 0. Consequently:
  - `disp_ready` = 1
  - `mul_i_valid` = 0
  - all issue data outputs = 0
- Dispatch at cycle N with both operands ready: the op is eligible at N+1 and issues at N+1 if `mul_idle` is high.
- CDB wakeup at cycle N: the entry is eligible at N+1.
- After an issue, `mul_idle` drops for the multiplier's busy period. Back-to-back issues therefore occur only as fast as `mul_idle` allows, with no extra bubble added here.
- Full, dispatch and issue in the same cycle: the dispatch is refused (`disp_ready` = 0) and the issue proceeds.
- Empty and `mul_idle` high: `mul_i_valid` stays 0.

## Configuration
- `MUL_RS_WAKEUP_BYPASS_EN` defined:
  - A CDB broadcast in cycle N also counts toward eligibility in cycle N.
  - The issue operand is taken from `cdb_data` combinationally, saving one cycle of wakeup-to-issue latency.
- Not defined: eligibility uses registered ready bits only, giving one cycle from wakeup to earliest issue.
- Dispatch-to-issue latency is 1 cycle in both configurations.

## Test plan
- **Basic issue.** Dispatch MUL (rob 2, rd 5, rs1 = 7, rs2 = 6, both ready) with `mul_idle` = 1 at cycle 0 -> at cycle 1 `mul_i_valid` = 1, `mul_rs1_data` = 7, `mul_rs2_data` = 6, `mul_i_rob_idx` = 2, `mul_i_rd` = 5; `rs_count` returns to 0.
- **Wakeup.** Dispatch MULH with rs2 waiting on tag 3, then `cdb_valid` with rob 3 and data 0xFFFF_FFFF at cycle 4 -> issue at cycle 5 (cycle 4 with the bypass macro) with `mul_rs2_data` = 0xFFFF_FFFF.
- **Age order.** Fill 4 entries with all operands ready and `mul_idle` held 0; then pulse `mul_idle` -> issues occur in dispatch order; `disp_ready` = 0 while `rs_count` = 4.
- **Out-of-order readiness.** Entry 0 waits on tag 6 while entry 1 is ready -> entry 1 issues first; entry 0 issues after the tag 6 broadcast.
- **Flush.** `flush` with 3 valid entries plus a same-cycle dispatch -> next cycle `rs_count` = 0 and `mul_i_valid` = 0, and no later issue of those ops.
- **Async reset.** Drive `rst` low mid-cycle while 2 entries are valid -> `rs_count` = 0 and `mul_i_valid` = 0 immediately, without waiting for a clock edge.
